pc_fetch_ctrl: RTL

//  Program-counter and fetch sequencer for the 9-bit CPU; sits directly upstream of the branch-target LUT.

---
 rtl/pc_fetch_ctrl_if.sv | 28 ++
 rtl/pc_fetch_ctrl.sv | 95 +++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-controller bus: decoder/LUT inputs and PC/status outputs.
interface pc_fetch_ctrl_if #(
  parameter int unsigned D  = 12,
  parameter int unsigned CW = 16
) ();
  logic          start;
  logic          stall;
  logic          branch_en;
  logic          halt;
  logic [D-1:0]  target;
  logic [D-1:0]  prog_ctr;
  logic          running;
  logic          done;
  logic          fault;
  logic [CW-1:0] instr_cnt;

  // Decoder / sequencer side
  modport master (
    output start, stall, branch_en, halt, target,
    input  prog_ctr, running, done, fault, instr_cnt
  );

  // Fetch controller side
  modport slave (
    input  start, stall, branch_en, halt, target,
    output prog_ctr, running, done, fault, instr_cnt
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Program counter and run/stop sequencer feeding the instruction ROM address.
// Taken branches add a signed LUT offset; out-of-range targets park the core in FAULT.
module pc_fetch_ctrl #(
  parameter int unsigned D        = 12,
  parameter int unsigned PROG_LEN = 1024,
  parameter int unsigned CW       = 16
) (
  input logic            Clk,
  input logic            Reset,
  pc_fetch_ctrl_if.slave bus
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;
  localparam logic [1:0] StFault = 2'd3;

  localparam logic [D-1:0]  PcOne      = D'(1);
  localparam logic [D-1:0]  LastPc     = D'(PROG_LEN - 1);
  // One extra bit so PROG_LEN == 2^D is representable
  localparam logic [D:0]    ProgLenExt = (D+1)'(PROG_LEN);
  localparam logic [CW-1:0] CntMax     = {CW{1'b1}};
  localparam logic [CW-1:0] CntOne     = CW'(1);

  logic [1:0]    state_q, state_d;
  logic [D-1:0]  pc_q, pc_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [D-1:0]  br_nxt;
  logic          br_ok;
  logic [CW-1:0] cnt_inc;

  // Branch target wraps modulo 2^D; a negative wrap lands high and fails the range check
  assign br_nxt  = pc_q + bus.target;
  assign br_ok   = ({1'b0, br_nxt} < ProgLenExt);
  assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + CntOne;

  // Next-state: stall > halt > branch > sequential increment while running
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d = StRun;
          pc_d    = '0;
          cnt_d   = '0;
        end
      end
      StRun: begin
        if (!bus.stall) begin
          if (bus.halt) begin
            state_d = StDone;
            cnt_d   = cnt_inc;
          end else if (bus.branch_en) begin
            if (br_ok) begin
              pc_d  = br_nxt;
              cnt_d = cnt_inc;
            end else begin
              state_d = StFault;
            end
          end else if (pc_q == LastPc) begin
            state_d = StDone;
            cnt_d   = cnt_inc;
          end else begin
            pc_d  = pc_q + PcOne;
            cnt_d = cnt_inc;
          end
        end
      end
      default: ; // FAULT is absorbing until Reset
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= StIdle;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.prog_ctr  = pc_q;
  assign bus.instr_cnt = cnt_q;
  assign bus.running   = (state_q == StRun);
  assign bus.done      = (state_q == StDone);
  assign bus.fault     = (state_q == StFault);

endmodule
